// File: rtl/fifo_test_pkg.sv
// Shared constants and types for the FIFO test engine: frame markers,
// command codes, status words and the controller state encoding.
package fifo_test_pkg;

    localparam logic [7:0]  FRAME_PREFIX = 8'hAA;
    localparam logic [7:0]  FRAME_SUFFIX = 8'h55;

    localparam logic [15:0] CODE_TX_GEN  = 16'hBEEF;
    localparam logic [15:0] CODE_RX_CHK  = 16'hCAFE;
    localparam logic [15:0] CODE_LED     = 16'h1ED0;
    localparam logic [15:0] CODE_LOOP    = 16'h100B;
    localparam logic [15:0] CODE_ERR_RD  = 16'hE4C7;
    localparam logic [15:0] CODE_ERR_CLR = 16'hC1EA;

    localparam logic [7:0]  STATUS_PASS  = 8'h42;
    localparam logic [7:0]  STATUS_FAIL  = 8'hEE;

    typedef enum logic [2:0] {
        CMD_WAIT,
        CMD_READ,
        CMD_PARSE,
        TX_GEN,
        RX_CHK,
        STATUS,
        LOOP_RD,
        LOOP_WR
    } state_t;

endpackage

// File: rtl/cmd_deframer.sv
// Sliding-window command assembler: every received word shifts into the
// LSBs of a 64-bit register; a frame is recognised whenever the window
// holds the prefix/suffix markers. A partial frame left idle too long is
// discarded so stale bytes never combine with a later command.
module cmd_deframer
    import fifo_test_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] word_in,
    input  logic              frame_clr,
    output logic [15:0]       code,
    output logic [31:0]       data,
    output logic              frame_valid
);

    logic [63:0]          shifter;
    logic [TIMEOUT_W-1:0] idle_cnt;

    // Shift in new words, drop consumed frames, and expire stale partial frames.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shifter  <= '0;
            idle_cnt <= '0;
        end else if (frame_clr) begin
            shifter  <= '0;
            idle_cnt <= '0;
        end else if (shift_en) begin
            shifter  <= {shifter[63-DATA_W:0], word_in};
            idle_cnt <= '0;
        end else if (shifter == '0) begin
            idle_cnt <= '0;
        end else if (idle_cnt == '1) begin
            shifter  <= '0;
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign code        = shifter[55:40];
    assign data        = shifter[39:8];
    assign frame_valid = (shifter[63:56] == FRAME_PREFIX) && (shifter[7:0] == FRAME_SUFFIX);

endmodule

// File: rtl/fifo_test_engine.sv
// FIFO test engine: receives framed commands from the host FIFO and runs
// pattern generation, pattern checking, loopback, LED and error-counter
// commands against the host/device FIFO pair.
module fifo_test_engine
    import fifo_test_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] rxfifo_data,
    input  logic              rxfifo_valid,
    input  logic              rxfifo_empty,
    output logic              rxfifo_rd,
    output logic [DATA_W-1:0] txfifo_data,
    output logic              txfifo_wr,
    input  logic              txfifo_full,
    output logic              led_out,
    output logic              busy,
    output logic [15:0]       err_cnt
);

    state_t            state, state_nxt;
    logic [31:0]       n_cnt, n_nxt;
    logic [DATA_W-1:0] gold_cnt, gold_nxt;
    logic              fail_flag, fail_nxt;
    logic [15:0]       err_nxt;
    logic              led_nxt;
    logic              wr_nxt;
    logic [DATA_W-1:0] txd_nxt;
    logic              rd_req;
    logic              rd_ok;
    logic              rd_pend;
    logic              run;
    logic              frame_clr;
    logic              shift_en;
    logic              tx_accept;
    logic              rx_mismatch;
    logic [15:0]       frame_code;
    logic [31:0]       frame_data;
    logic              frame_valid;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] fit_word(input logic [15:0] v);
        return DATA_W'(v);
    endfunction

    cmd_deframer #(
        .DATA_W    (DATA_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_deframer (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .shift_en    (shift_en),
        .word_in     (rxfifo_data),
        .frame_clr   (frame_clr),
        .code        (frame_code),
        .data        (frame_data),
        .frame_valid (frame_valid)
    );

    // Only command bytes enter the shifter; test payload words bypass it.
    assign shift_en    = (state == CMD_READ) && rxfifo_valid;
    // run gates the read strobe so nothing is requested while reset is held.
    assign rd_ok       = run && !rxfifo_empty;
    assign rxfifo_rd   = rd_req && rd_ok;
    assign tx_accept   = txfifo_wr && !txfifo_full;
    assign rx_mismatch = (rxfifo_data != gold_cnt);
    assign busy        = (state != CMD_WAIT);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= CMD_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus next values of every counter and FIFO strobe.
    always_comb begin
        state_nxt = state;
        n_nxt     = n_cnt;
        gold_nxt  = gold_cnt;
        fail_nxt  = fail_flag;
        err_nxt   = err_cnt;
        led_nxt   = led_out;
        wr_nxt    = txfifo_wr;
        txd_nxt   = txfifo_data;
        rd_req    = 1'b0;
        frame_clr = 1'b0;
        case (state)
            CMD_WAIT: begin
                rd_req = 1'b1;
                if (rd_ok) state_nxt = CMD_READ;
            end
            CMD_READ: begin
                if (rxfifo_valid) state_nxt = CMD_PARSE;
            end
            CMD_PARSE: begin
                state_nxt = CMD_WAIT;
                if (frame_valid) begin
                    frame_clr = 1'b1;
                    case (frame_code)
                        CODE_TX_GEN: begin
                            n_nxt    = frame_data;
                            gold_nxt = '0;
                            txd_nxt  = '0;
                            if (frame_data != 32'd0) begin
                                wr_nxt    = 1'b1;
                                state_nxt = TX_GEN;
                            end
                        end
                        CODE_RX_CHK: begin
                            n_nxt    = frame_data;
                            gold_nxt = '0;
                            fail_nxt = 1'b0;
                            if (frame_data == 32'd0) begin
                                wr_nxt    = 1'b1;
                                txd_nxt   = DATA_W'(STATUS_PASS);
                                state_nxt = STATUS;
                            end else begin
                                state_nxt = RX_CHK;
                            end
                        end
                        CODE_LED: begin
                            led_nxt = frame_data[0];
                        end
                        CODE_LOOP: begin
                            n_nxt = frame_data;
                            if (frame_data != 32'd0) state_nxt = LOOP_RD;
                        end
                        CODE_ERR_RD: begin
                            wr_nxt    = 1'b1;
                            txd_nxt   = fit_word(err_cnt);
                            state_nxt = STATUS;
                        end
                        CODE_ERR_CLR: begin
                            err_nxt = 16'd0;
                        end
                        default: begin
                            err_nxt = sat_inc(err_cnt);
                        end
                    endcase
                end
            end
            TX_GEN: begin
                if (tx_accept) begin
                    n_nxt    = n_cnt - 32'd1;
                    gold_nxt = gold_cnt + 1'b1;
                    txd_nxt  = gold_cnt + 1'b1;
                    if (n_cnt == 32'd1) begin
                        wr_nxt    = 1'b0;
                        state_nxt = CMD_WAIT;
                    end
                end
            end
            RX_CHK: begin
                rd_req = !rd_pend;
                if (rxfifo_valid) begin
                    n_nxt    = n_cnt - 32'd1;
                    gold_nxt = gold_cnt + 1'b1;
                    if (rx_mismatch) begin
                        err_nxt  = sat_inc(err_cnt);
                        fail_nxt = 1'b1;
                    end
                    if (n_cnt == 32'd1) begin
                        wr_nxt    = 1'b1;
                        txd_nxt   = (fail_flag || rx_mismatch) ? DATA_W'(STATUS_FAIL)
                                                               : DATA_W'(STATUS_PASS);
                        state_nxt = STATUS;
                    end
                end
            end
            STATUS: begin
                if (tx_accept) begin
                    wr_nxt    = 1'b0;
                    state_nxt = CMD_WAIT;
                end
            end
            LOOP_RD: begin
                rd_req = !rd_pend;
                if (rxfifo_valid) begin
                    txd_nxt   = rxfifo_data;
                    wr_nxt    = 1'b1;
                    state_nxt = LOOP_WR;
                end
            end
            LOOP_WR: begin
                if (tx_accept) begin
                    wr_nxt    = 1'b0;
                    n_nxt     = n_cnt - 32'd1;
                    state_nxt = (n_cnt == 32'd1) ? CMD_WAIT : LOOP_RD;
                end
            end
            default: begin
                state_nxt = CMD_WAIT;
            end
        endcase
    end

    // Counters, flags and registered FIFO outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run         <= 1'b0;
            rd_pend     <= 1'b0;
            n_cnt       <= '0;
            gold_cnt    <= '0;
            fail_flag   <= 1'b0;
            err_cnt     <= '0;
            led_out     <= 1'b0;
            txfifo_wr   <= 1'b0;
            txfifo_data <= '0;
        end else begin
            run         <= 1'b1;
            rd_pend     <= rxfifo_rd;
            n_cnt       <= n_nxt;
            gold_cnt    <= gold_nxt;
            fail_flag   <= fail_nxt;
            err_cnt     <= err_nxt;
            led_out     <= led_nxt;
            txfifo_wr   <= wr_nxt;
            txfifo_data <= txd_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_test_engine.sv
// Directed/randomised bench for fifo_test_engine with a queue-based FIFO
// environment and a command-level reference model.
module tb_fifo_test_engine;

    localparam int DW   = 8;
    localparam int TW   = 10;
    localparam int HALF = 5;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [DW-1:0] rxfifo_data;
    logic          rxfifo_valid;
    logic          rxfifo_empty;
    logic          rxfifo_rd;
    logic [DW-1:0] txfifo_data;
    logic          txfifo_wr;
    logic          txfifo_full;
    logic          led_out;
    logic          busy;
    logic [15:0]   err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tx_got[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] words[$];
    bit            rd_taken;
    bit            tx_hold;
    logic [DW-1:0] tx_hold_data;
    int            full_pct;
    int            err_model;
    int            led_model;
    int            sz;

    fifo_test_engine #(
        .DATA_W    (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rxfifo_data  (rxfifo_data),
        .rxfifo_valid (rxfifo_valid),
        .rxfifo_empty (rxfifo_empty),
        .rxfifo_rd    (rxfifo_rd),
        .txfifo_data  (txfifo_data),
        .txfifo_wr    (txfifo_wr),
        .txfifo_full  (txfifo_full),
        .led_out      (led_out),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #HALF sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO environment: RX queue with 1-cycle read latency, random TX backpressure.
    initial begin
        rd_taken = 1'b0;
        tx_hold  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rd_taken && rx_q.size() > 0) begin
                rxfifo_valid = 1'b1;
                rxfifo_data  = rx_q.pop_front();
            end else begin
                rxfifo_valid = 1'b0;
                rxfifo_data  = DW'($urandom);
            end
            rxfifo_empty = (rx_q.size() == 0);
            txfifo_full  = ($urandom_range(99, 0) < 32'(full_pct));
            #(HALF - 1);
            rd_taken = rxfifo_rd;
            if (rxfifo_rd) begin
                n_tests++;
                assert (!rxfifo_empty)
                else begin
                    n_fail++;
                    $error("FAIL rd_when_empty: observed rd=1 empty=1, expected no read");
                end
            end
            if (tx_hold && sys_rst_n) begin
                n_tests++;
                assert (txfifo_wr === 1'b1 && txfifo_data === tx_hold_data)
                else begin
                    n_fail++;
                    $error("FAIL tx_hold: observed wr=%0b data=0x%0h, expected wr=1 data=0x%0h",
                           txfifo_wr, txfifo_data, tx_hold_data);
                end
            end
            if (txfifo_wr && !txfifo_full) begin
                tx_got.push_back(txfifo_data);
                tx_hold = 1'b0;
            end else begin
                tx_hold      = txfifo_wr && sys_rst_n;
                tx_hold_data = txfifo_data;
            end
        end
    end

    task automatic send_frame(input logic [15:0] code, input logic [31:0] data);
        rx_q.push_back(8'hAA);
        rx_q.push_back(code[15:8]);
        rx_q.push_back(code[7:0]);
        rx_q.push_back(data[31:24]);
        rx_q.push_back(data[23:16]);
        rx_q.push_back(data[15:8]);
        rx_q.push_back(data[7:0]);
        rx_q.push_back(8'h55);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int quiet = 0;
        int cyc   = 0;
        while (quiet < 4 && cyc < budget) begin
            @(negedge sys_clk);
            #(HALF - 2);
            cyc++;
            if (rx_q.size() == 0 && !rd_taken && !busy && !rxfifo_valid) quiet++;
            else quiet = 0;
        end
        n_tests++;
        assert (quiet >= 4)
        else begin
            n_fail++;
            $error("FAIL %s_timeout: observed busy after %0d cycles, expected idle", tag, cyc);
        end
    endtask

    // Compare collected TX words against the model's expected stream, then clear.
    task automatic check_tx(input string tag);
        check({tag, "_len"}, 32'(tx_got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < tx_got.size())
                check($sformatf("%s[%0d]", tag, i), 32'(tx_got[i]), 32'(exp_q[i]));
        end
        tx_got.delete();
        exp_q.delete();
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        rxfifo_valid = 1'b0;
        rxfifo_empty = 1'b1;
        rxfifo_data  = '0;
        txfifo_full  = 1'b0;
        full_pct     = 0;
        err_model    = 0;
        led_model    = 0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        #1;
        check("rst_wr",   32'(txfifo_wr),   32'd0);
        check("rst_data", 32'(txfifo_data), 32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_led",  32'(led_out),     32'd0);
        check("rst_err",  32'(err_cnt),     32'd0);
        check("rst_rd",   32'(rxfifo_rd),   32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Pattern generation, 300 words with random backpressure
        full_pct = 50;
        send_frame(16'hBEEF, 32'd300);
        wait_quiet("beef300", 5000);
        for (int i = 0; i < 300; i++) exp_q.push_back(DW'(i % (1 << DW)));
        check_tx("beef300");

        // Pattern generation with N = 0
        send_frame(16'hBEEF, 32'd0);
        wait_quiet("beef0", 500);
        check_tx("beef0");

        // Pattern check, all good
        full_pct = 30;
        send_frame(16'hCAFE, 32'd5);
        for (int i = 0; i < 5; i++) rx_q.push_back(DW'(i));
        wait_quiet("cafe_ok", 500);
        exp_q.push_back(8'h42);
        check_tx("cafe_ok");
        check("cafe_ok_err", 32'(err_cnt), 32'(err_model));

        // Pattern check, one bad word
        send_frame(16'hCAFE, 32'd5);
        words = '{8'd0, 8'd1, 8'd9, 8'd3, 8'd4};
        foreach (words[i]) begin
            rx_q.push_back(words[i]);
            if (words[i] != DW'(i)) err_model++;
        end
        wait_quiet("cafe_bad", 500);
        exp_q.push_back(8'hEE);
        check_tx("cafe_bad");
        check("cafe_bad_err", 32'(err_cnt), 32'(err_model));

        // Pattern check with N = 0 answers at once
        send_frame(16'hCAFE, 32'd0);
        wait_quiet("cafe0", 500);
        exp_q.push_back(8'h42);
        check_tx("cafe0");

        // Loopback after leading garbage
        for (int i = 0; i < 3; i++) rx_q.push_back(DW'($urandom));
        send_frame(16'h100B, 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(DW'($urandom));
            rx_q.push_back(exp_q[i]);
        end
        wait_quiet("loop", 500);
        check_tx("loop");

        // LED off via data bit 0 = 0
        full_pct = 0;
        send_frame(16'h1ED0, 32'd2);
        wait_quiet("led0", 500);
        check("led0", 32'(led_out), 32'(led_model));

        // Partial frame expires; its tail alone must not form a command
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h1E);
        rx_q.push_back(8'hD0);
        rx_q.push_back(8'h00);
        wait_quiet("partial", 500);
        repeat ((1 << TW) + 20) @(negedge sys_clk);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h55);
        wait_quiet("tail", 500);
        check("stale_led", 32'(led_out), 32'(led_model));
        check("stale_err", 32'(err_cnt), 32'(err_model));
        send_frame(16'h1ED0, 32'd1);
        wait_quiet("led1", 500);
        led_model = 1;
        check("led1", 32'(led_out), 32'(led_model));
        check_tx("led_notx");

        // Unknown code, error readback, error clear
        send_frame(16'h1234, 32'h0000_0000);
        err_model++;
        wait_quiet("unknown", 500);
        check("unknown_err", 32'(err_cnt), 32'(err_model));
        send_frame(16'hE4C7, 32'd0);
        wait_quiet("err_rd", 500);
        exp_q.push_back(DW'(err_model));
        check_tx("err_rd");
        send_frame(16'hC1EA, 32'd0);
        err_model = 0;
        wait_quiet("err_clr", 500);
        check("err_clr", 32'(err_cnt), 32'(err_model));
        send_frame(16'h1234, 32'd7);
        err_model++;
        wait_quiet("unknown2", 500);
        check("unknown2_err", 32'(err_cnt), 32'(err_model));

        // Asynchronous reset in the middle of pattern generation
        full_pct = 50;
        send_frame(16'hBEEF, 32'd200);
        repeat (60) @(negedge sys_clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("arst_wr",   32'(txfifo_wr),   32'd0);
        check("arst_data", 32'(txfifo_data), 32'd0);
        check("arst_busy", 32'(busy),        32'd0);
        check("arst_led",  32'(led_out),     32'd0);
        check("arst_err",  32'(err_cnt),     32'd0);
        check("arst_rd",   32'(rxfifo_rd),   32'd0);
        sz = tx_got.size();
        repeat (5) @(negedge sys_clk);
        #1;
        check("arst_quiet", 32'(tx_got.size()), 32'(sz));
        rx_q.delete();
        tx_got.delete();
        led_model = 0;
        err_model = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_frame(16'hBEEF, 32'd10);
        wait_quiet("post_rst", 2000);
        for (int i = 0; i < 10; i++) exp_q.push_back(DW'(i));
        check_tx("post_rst");
        send_frame(16'hE4C7, 32'd0);
        wait_quiet("post_rst_err", 500);
        exp_q.push_back(DW'(err_model));
        check_tx("post_rst_err");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_test_engine.md
FIFO_TEST_ENGINE -- requirements
Module: fifo_test_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning FIFO word width; legal values 8, 16, 32.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, meaning width of the partial-command timeout counter.
REQ-003 SHALL have port sys_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports rxfifo_data (input, DATA_W), rxfifo_valid (input, 1), rxfifo_empty (input, 1) and rxfifo_rd (output, 1), meaning the host-to-device FIFO read side; valid follows rd by exactly 1 cycle.
REQ-006 SHALL have ports txfifo_data (output, DATA_W), txfifo_wr (output, 1) and txfifo_full (input, 1), meaning the device-to-host FIFO write side.
REQ-007 SHALL have ports led_out (output, 1), busy (output, 1; state != CMD_WAIT) and err_cnt (output, 16; saturating pattern-error count).

Function
REQ-008 SHALL assemble commands in a 64-bit shifter: each received word enters the LSBs and older data shifts toward the MSBs; frame = {prefix[63:56], code[55:40], data[39:8], suffix[7:0]}, and the host sends the prefix first.
REQ-009 SHALL treat a frame as valid when prefix == 0xAA and suffix == 0x55, checked after every received word (sliding window), so a frame is recovered without any realignment step.
REQ-010 SHALL, on a valid frame with an unknown code, clear the shifter, increment err_cnt and return to CMD_WAIT.
REQ-011 SHALL use states CMD_WAIT, CMD_READ, CMD_PARSE, TX_GEN, RX_CHK, STATUS, LOOP_RD, LOOP_WR.
REQ-012 SHALL assert rxfifo_rd only in a cycle where rxfifo_empty is low.
REQ-013 SHALL capture rxfifo_data only when rxfifo_valid is high.
REQ-014 SHALL hold txfifo_data and txfifo_wr stable until accepted; a word is accepted in a cycle where txfifo_wr = 1 and txfifo_full = 0.
REQ-015 SHALL, for code 0xBEEF, load N = data and transmit N words of value 0, 1, 2, ... (modulo 2^DATA_W), then return to CMD_WAIT; N = 0 transmits nothing.
REQ-016 SHALL, for code 0xCAFE, read N words and compare each with a golden counter starting at 0 that wraps at 2^DATA_W.
REQ-017 SHALL, on each 0xCAFE mismatch, increment err_cnt and set a sticky fail flag.
REQ-018 SHALL, after 0xCAFE completes, send one STATUS word: 0x42 if no mismatch, else 0xEE, zero-extended to DATA_W; N = 0 sends 0x42 immediately.
REQ-019 SHALL, for code 0x1ED0, set led_out = data[0] with no TX traffic.
REQ-020 SHALL, for code 0x100B, echo N received words unchanged to TX in order, alternating LOOP_RD and LOOP_WR with one word in flight.
REQ-021 SHALL, for code 0xE4C7, send err_cnt zero-extended or truncated to DATA_W as one STATUS word.
REQ-022 SHALL, for code 0xC1EA, clear err_cnt.
REQ-023 SHALL saturate err_cnt at 0xFFFF.
REQ-024 SHALL count cycles with a partial command in the shifter and no new word, and on reaching 2^TIMEOUT_W-1 clear the shifter and stay in CMD_WAIT.
REQ-025 SHALL use a 32-bit N counter that decrements once per accepted or checked word; a command ends when the counter is 0.
REQ-026 SHALL ignore RX data while in TX_GEN and STATUS, and ignore new commands until the current test completes.

Reset
REQ-027 SHALL, while sys_rst_n is low, force: state = CMD_WAIT, shifter = 0, rxfifo_rd = 0, txfifo_wr = 0, txfifo_data = 0, led_out = 0, busy = 0, err_cnt = 0, N counter = 0, golden counter = 0, fail flag = 0, timeout counter = 0.
REQ-028 SHALL abandon any test in progress when reset is asserted, with no further FIFO strobes after reset asserts.

Structure
REQ-029 SHALL place the command codes, prefix/suffix constants, status constants and the state enum typedef in shared package fifo_test_pkg.
REQ-030 SHALL implement frame assembly, validity check and timeout in one sub-module, cmd_deframer, which outputs code, data and frame_valid.

Verification
REQ-031 SHALL verify: BEEF with N = 300 and DATA_W = 8, random txfifo_full -> 300 words 0..255, 0..43, none lost or duplicated.
REQ-032 SHALL verify: CAFE with N = 5, data 0..4 -> one word 0x42; data 0,1,9,3,4 -> 0xEE and err_cnt = 1.
REQ-033 SHALL verify: 3 garbage bytes then frame AA 10 0B 00 00 00 04 55 followed by 4 words -> same 4 words echoed in order.
REQ-034 SHALL verify: 4 bytes of a frame then idle for 2^TIMEOUT_W cycles, then a full 1ED0 frame with data 1 -> led_out = 1 and no stale bytes used.
REQ-035 SHALL verify: valid frame with code 0x1234 -> err_cnt increments; E4C7 -> that count returned; C1EA -> err_cnt = 0.
REQ-036 SHALL verify: sys_rst_n pulsed low mid-BEEF -> all outputs reach reset values asynchronously and the next command executes normally.
